// File: rtl/mult_div_unit_if.sv
// Bundle of the request, mthi/mtlo and HI/LO result signals of mult_div_unit.
//   master : execute-stage control (drives request and mthi/mtlo strobes)
//   slave  : mult_div_unit (drives busy/done/div_by_zero and HI/LO)
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       alu_funct;
  logic             is_unsigned;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alu_funct, is_unsigned, op_a, op_b, hi_we, lo_we, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, alu_funct, is_unsigned, op_a, op_b, hi_we, lo_we, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Radix-2 shift-add multiply or restoring divide on operand magnitudes,
// one iteration per cycle for WIDTH cycles, then sign fix-up and HI/LO write.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : slave side of mult_div_unit_if (request, mthi/mtlo, status, HI/LO)
//
// state  | meaning
// IDLE   | waiting for start; mthi/mtlo writes accepted here only
// CALC   | one multiply/divide iteration per cycle, counter counts down
// FIX    | sign correction, HI/LO written at this edge
// DONE   | done pulse for one cycle, start ignored
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         reset_n,
  mult_div_unit_if.slave bus
);
  localparam logic [4:0] FUNCT_MULT = 5'b00100;
  localparam logic [4:0] FUNCT_DIV  = 5'b01001;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic               w_accept;
  logic               w_is_div;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dshift;
  logic               w_dge;
  logic [WIDTH-1:0]   w_ddiff;
  logic [WIDTH-1:0]   w_drem;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_dbz;

  assign w_is_div = (bus.alu_funct == FUNCT_DIV);
  assign w_accept = bus.start && ((bus.alu_funct == FUNCT_MULT) || w_is_div);

  // Sign bits are forced to 0 in unsigned mode so magnitudes are the raw operands.
  assign w_sign_a = !bus.is_unsigned && bus.op_a[WIDTH-1];
  assign w_sign_b = !bus.is_unsigned && bus.op_b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? -bus.op_a : bus.op_a;
  assign w_mag_b  = w_sign_b ? -bus.op_b : bus.op_b;

  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                  {1'b0, (r_acc[0] ? r_mag_a : {WIDTH{1'b0}})};

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
  // The shifted remainder can need WIDTH+1 bits, but after a successful
  // subtract the result always fits back into WIDTH bits.
  assign w_dshift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_dge    = (w_dshift >= {1'b0, r_mag_b});
  assign w_ddiff  = w_dshift[WIDTH-1:0] - r_mag_b;
  assign w_drem   = w_dge ? w_ddiff : w_dshift[WIDTH-1:0];

  assign w_acc_next = r_is_div ? {w_drem, r_acc[WIDTH-2:0], w_dge}
                               : {w_msum, r_acc[WIDTH-1:1]};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_dbz  = (r_mag_b == {WIDTH{1'b0}});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a_raw  <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div <= w_is_div;
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            r_a_raw  <= bus.op_a;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
            r_cnt    <= CNT_W'(WIDTH);
            r_dbz    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end else begin
            if (bus.hi_we) r_hi <= bus.wr_data;
            if (bus.lo_we) r_lo <= bus.wr_data;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            if (w_dbz) begin
              r_lo  <= '1;
              r_hi  <= r_a_raw;
              r_dbz <= 1'b1;
            end else begin
              r_lo <= w_quot;
              r_hi <= w_rem;
            end
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  localparam int W = 32;
  localparam logic [4:0] F_MULT = 5'b00100;
  localparam logic [4:0] F_DIV  = 5'b01001;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  exp_t exp_q[$];
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the operand values.
  function automatic exp_t model(input bit is_div, input bit uns,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb;
    logic [63:0] t;
    sa = uns ? longint'({32'd0, a}) : longint'($signed(a));
    sb = uns ? longint'({32'd0, b}) : longint'($signed(b));
    e.dbz = 1'b0;
    if (!is_div) begin
      t = sa * sb;
      e.hi = t[63:32];
      e.lo = t[31:0];
    end else if (b == '0) begin
      e.lo  = '1;
      e.hi  = a;
      e.dbz = 1'b1;
    end else begin
      t = sa / sb;
      e.lo = t[31:0];
      t = sa % sb;
      e.hi = t[31:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_hi", bus.hi, e.hi);
        chk("result_lo", bus.lo, e.lo);
        chk("result_dbz", bus.div_by_zero, e.dbz);
      end
    end
  end

  // hz: 0 none, 1 hi_we while busy, 2 second start mid-op,
  //     3 reset during CALC, 4 lo_we together with start
  // Called at #1 after a rising edge with the unit idle.
  task automatic run_op(input bit is_div, input bit uns,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int hz);
    exp_t e;
    int n, nb;
    bit seen;
    e = model(is_div, uns, a, b);
    bus.start       = 1'b1;
    bus.alu_funct   = is_div ? F_DIV : F_MULT;
    bus.is_unsigned = uns;
    bus.op_a        = a;
    bus.op_b        = b;
    if (hz == 4) begin
      bus.lo_we   = 1'b1;
      bus.wr_data = 32'h5A5A5A5A;
    end
    if (hz != 3) exp_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    bus.is_unsigned = $urandom_range(0, 1);
    chk("dbz_cleared_on_start", bus.div_by_zero, 1'b0);
    nb   = bus.busy ? 1 : 0;
    n    = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      if (hz == 1 && n == 3) begin
        bus.hi_we   = 1'b1;
        bus.wr_data = 32'hA5A5A5A5;
      end
      if (hz == 2 && n == 5) begin
        bus.start     = 1'b1;
        bus.alu_funct = is_div ? F_MULT : F_DIV;
        bus.op_a      = $urandom;
        bus.op_b      = $urandom;
      end
      if (hz == 3 && n == 10) reset_n = 1'b0;
      @(posedge clk); #1;
      n++;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      if (hz == 1 && n == 4) chk("hi_we_while_busy", bus.hi, exp_hi);
      if (hz == 3 && n == 11) begin
        reset_n = 1'b1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_hi", bus.hi, '0);
        chk("abort_lo", bus.lo, '0);
        exp_hi = '0;
        exp_lo = '0;
        repeat (W + 8) @(posedge clk);
        #1;
        return;
      end
      if (bus.done) seen = 1'b1;
      else if (bus.busy) nb++;
    end
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
      return;
    end
    chk("latency_edges", n, W + 1);
    chk("busy_cycles", nb, W + 1);
    if (hz == 4) chk("lo_we_dropped", bus.lo, e.lo);
    exp_hi = e.hi;
    exp_lo = e.lo;
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 1'b0);
  endtask

  task automatic mt_write(input bit to_hi, input logic [W-1:0] d);
    bus.hi_we   = to_hi;
    bus.lo_we   = !to_hi;
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    if (to_hi) begin
      exp_hi = d;
      chk("mthi", bus.hi, d);
    end else begin
      exp_lo = d;
      chk("mtlo", bus.lo, d);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_hi = '0;
    exp_lo = '0;
    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.alu_funct   = '0;
    bus.is_unsigned = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.hi_we       = 1'b0;
    bus.lo_we       = 1'b0;
    bus.wr_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_dbz", bus.div_by_zero, 1'b0);
    chk("reset_hi", bus.hi, '0);
    chk("reset_lo", bus.lo, '0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 1'b0, 32'hFFFFFFFD, 32'd7, 0);
    run_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 0);
    run_op(1'b1, 1'b1, 32'd100, 32'd7, 0);
    run_op(1'b1, 1'b1, 32'h12345678, 32'd0, 0);
    run_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(1'b1, 1'b0, 32'h80000000, 32'd0, 0);
    run_op(1'b0, 1'b0, 32'h80000000, 32'h80000000, 0);

    mt_write(1'b1, 32'h0BADF00D);
    mt_write(1'b0, 32'hCAFE1234);

    // Unknown function code with start: no operation, mthi still honoured.
    bus.start     = 1'b1;
    bus.alu_funct = 5'b00000;
    bus.hi_we     = 1'b1;
    bus.wr_data   = 32'h13572468;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    exp_hi = 32'h13572468;
    chk("bad_funct_not_busy", bus.busy, 1'b0);
    chk("bad_funct_mthi", bus.hi, exp_hi);

    run_op(1'b0, 1'b1, 32'd12345, 32'd678, 1);
    run_op(1'b1, 1'b0, 32'hFFFF0000, 32'd3, 2);
    run_op(1'b0, 1'b0, 32'd9, 32'hFFFFFFFB, 4);
    run_op(1'b1, 1'b1, 32'hDEADBEEF, 32'd17, 3);
    chk("after_abort_hi", bus.hi, exp_hi);
    run_op(1'b1, 1'b0, -32'sd100, -32'sd7, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op($urandom_range(0, 1), $urandom_range(0, 1), a, b, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
